bin2bcd_seq_311: RTL and testbench
==================================

Name: bin2bcd_seq_311

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It sits directly downstream of down_counter_311. It samples the 8-bit count_311 value on a start request and produces three packed BCD digits for the seven-segment/display stage. One bit is processed per clock, using a start/busy/done handshake.

Parameters:
WIDTH, 8, binary input width; must be at least 2.
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1. Out-of-range settings are unsupported; a bench assertion flags them.

Ports:
clk_311  input  1  system clock, rising-edge active
reset_311  input  1  asynchronous, active-low reset (0 = reset)
start_311  input  1  conversion request, level-sampled on the rising edge
bin_in_311  input  WIDTH  binary value, normally driven by count_311
busy_311  output  1  high while shifting
done_311  output  1  one-cycle pulse: bcd_311 has just been updated
bcd_311  output  4*DIGITS  packed BCD result; [3:0] = units, [7:4] = tens, [11:8] = hundreds

Behaviour:
- Reset (reset_311=0, asynchronous): state=IDLE, shift register=0, bit counter=0, busy_311=0, done_311=0, bcd_311=0. Reset deasserts synchronously to clk_311 by system design.
- FSM states: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE: if start_311=1 at an edge, load scratch = {4*DIGITS zeros, bin_in_311}, set counter=0, go to SHIFT; otherwise stay in IDLE.
- SHIFT, each edge:
  - Apply the add-3 correction to every BCD nibble of scratch that is >=5.
  - Shift the whole scratch left by 1 and increment the counter.
  - On the shift where counter==WIDTH-1, write the upper 4*DIGITS bits of the shifted value to bcd_311 and go to DONE.
- DONE: lasts exactly one cycle. If start_311=1, accept a new conversion as in IDLE (go to SHIFT); otherwise go to IDLE.
- busy_311 = (state==SHIFT). done_311 = (state==DONE).
- Latency: accept at edge E0; shifts at E1..EWIDTH; bcd_311 updates and done_311 rises after edge EWIDTH. With the default, that is 8 cycles after acceptance.
- Throughput: back-to-back conversions every WIDTH+1 cycles (9 at the default).
- start_311 while busy_311=1 is ignored. It is not queued.
- bin_in_311 is sampled only at acceptance; changes during SHIFT have no effect.
- bcd_311 holds its value between done pulses and is never partially updated.
- Range: no overflow is possible under the DIGITS rule. Unused high digits read 0.
- Reset mid-conversion aborts immediately to the reset values. No done pulse follows, and the previous result is lost.

Decomposition:
- Package bin2bcd_pkg_311 holds:
  - state enum (IDLE, SHIFT, DONE);
  - BCD_NIBBLE_W = 4;
  - ADD3_THRESHOLD = 5;
  - helper function for the counter width: clog2 of WIDTH.
- Sub-module add3_digit_311 is the natural split: a combinational 4-bit in, 4-bit out nibble corrector (returns nibble+3 if nibble>=5). It is instantiated DIGITS times via generate.

Test Plan:
- Reset, then start with bin_in=8'd255 -> busy for 8 cycles; done pulses once; bcd_311=12'h255; busy=0 afterwards.
- bin_in=0 -> bcd=12'h000 with done after 8 cycles. bin_in=99 -> 12'h099. bin_in=100 -> 12'h100 (digit-boundary carry).
- Convert 37, then pulse start every cycle during SHIFT with bin_in=200 -> only one done; bcd=12'h037; no second conversion starts until DONE/IDLE.
- Hold start=1 continuously with bin_in alternating 128/64 at acceptance -> done every 9 cycles; results 12'h128 then 12'h064.
- After a valid result 12'h042, start 250 and drop reset_311 at shift 4 -> outputs 0 immediately; no done. After release, converting 250 -> 12'h250.
- Drive bin_in from down_counter_311 and sweep all 256 values, restarting on each done -> every result matches the scoreboard model (hundreds = n/100, tens = (n/10)%10, units = n%10).

Source files
------------

// File: rtl/bin2bcd_pkg_311.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bin2bcd_pkg_311;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned BCD_NIBBLE_W   = 4;
  localparam int unsigned ADD3_THRESHOLD = 5;

  // Bit-counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/add3_digit_311.sv
// Combinational BCD nibble corrector: adds 3 when the nibble is 5 or more.
module add3_digit_311
  import bin2bcd_pkg_311::*;
(
  input  logic [BCD_NIBBLE_W-1:0] nib_i,
  output logic [BCD_NIBBLE_W-1:0] nib_o
);

  always_comb begin
    nib_o = nib_i;
    if (nib_i >= BCD_NIBBLE_W'(ADD3_THRESHOLD)) begin
      nib_o = nib_i + BCD_NIBBLE_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq_311.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with start/busy/done handshake and registered outputs.
module bin2bcd_seq_311
  import bin2bcd_pkg_311::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk_311,
  input  logic                          reset_311,
  input  logic                          start_311,
  input  logic [WIDTH-1:0]              bin_in_311,
  output logic                          busy_311,
  output logic                          done_311,
  output logic [BCD_NIBBLE_W*DIGITS-1:0] bcd_311
);

  localparam int unsigned BCD_W = BCD_NIBBLE_W * DIGITS;
  localparam int unsigned SW    = BCD_W + WIDTH;
  localparam int unsigned CW    = cnt_width(WIDTH);

  state_e          state_q, state_d;
  logic [SW-1:0]   scratch_q, scratch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;

  logic [BCD_W-1:0] corr_hi;
  logic [SW-1:0]    corrected;
  logic [SW-1:0]    shifted;

  // Only the BCD region of the scratch register is corrected; the binary tail passes through.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    add3_digit_311 u_add3 (
      .nib_i (scratch_q[WIDTH + BCD_NIBBLE_W*g +: BCD_NIBBLE_W]),
      .nib_o (corr_hi[BCD_NIBBLE_W*g +: BCD_NIBBLE_W])
    );
  end

  assign corrected = {corr_hi, scratch_q[WIDTH-1:0]};
  assign shifted   = corrected << 1;

  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_311) begin
          scratch_d = {{BCD_W{1'b0}}, bin_in_311};
          cnt_d     = '0;
          state_d   = SHIFT;
        end else begin
          state_d   = IDLE;
        end
      end
      SHIFT: begin
        scratch_d = shifted;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d   = shifted[SW-1 -: BCD_W];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_311 or negedge reset_311) begin
    if (!reset_311) begin
      state_q   <= IDLE;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
    end
  end

  assign busy_311 = (state_q == SHIFT);
  assign done_311 = (state_q == DONE);
  assign bcd_311  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq_311.sv
// Scoreboard bench for bin2bcd_seq_311: stimulus pushes expected BCD, a monitor pops on done.
module tb_bin2bcd_seq_311;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = 3;

  logic             clk_311 = 1'b0;
  logic             reset_311;
  logic             start_311;
  logic [WIDTH-1:0] bin_in_311;
  logic             busy_311;
  logic             done_311;
  logic [11:0]      bcd_311;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [11:0] sb[$];

  bin2bcd_seq_311 #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk_311    (clk_311),
    .reset_311  (reset_311),
    .start_311  (start_311),
    .bin_in_311 (bin_in_311),
    .busy_311   (busy_311),
    .done_311   (done_311),
    .bcd_311    (bcd_311)
  );

  always #5 clk_311 = ~clk_311;
  always @(posedge clk_311) cyc <= cyc + 1;

  initial begin
    assert (WIDTH >= 2 && (10 ** DIGITS) > (2 ** WIDTH) - 1)
      else $error("parameter setting out of supported range");
  end

  function automatic logic [11:0] bcd_model(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk_311) begin
    if (reset_311 && done_311) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got bcd=%h with no pending conversion", bcd_311);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        if (bcd_311 !== e) begin
          errors++;
          $display("FAIL bcd_result got %h expected %h", bcd_311, e);
        end
      end
    end
  end

  task automatic wait_done(output bit seen, output int busy_cnt);
    seen = 0;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_311);
      if (done_311) begin
        seen = 1;
        break;
      end
      busy_cnt += int'(busy_311);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout got no done within 30 cycles required done");
    end
  endtask

  task automatic convert(input logic [7:0] v, input logic [11:0] exp);
    bit seen;
    int bc;
    @(negedge clk_311);
    start_311  = 1'b1;
    bin_in_311 = v;
    sb.push_back(exp);
    @(posedge clk_311);
    #1;
    start_311  = 1'b0;
    bin_in_311 = ~v;
    wait_done(seen, bc);
    if (seen) begin
      checks++;
      if (bc != 8) begin
        errors++;
        $display("FAIL busy_cycles got %0d required 8 (value %0d)", bc, v);
      end
    end
    @(negedge clk_311);
    checks++;
    if (done_311 !== 1'b0 || busy_311 !== 1'b0 || bcd_311 !== exp) begin
      errors++;
      $display("FAIL after_done got done=%b busy=%b bcd=%h required 0 0 %h",
               done_311, busy_311, bcd_311, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int bc, t1, t2, dcount;
    logic [7:0] count_311;

    reset_311  = 1'b0;
    start_311  = 1'b0;
    bin_in_311 = '0;
    repeat (3) @(negedge clk_311);
    checks++;
    if (busy_311 !== 1'b0 || done_311 !== 1'b0 || bcd_311 !== 12'h000) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b bcd=%h required 0 0 000",
               busy_311, done_311, bcd_311);
    end
    reset_311 = 1'b1;

    convert(8'd255, 12'h255);
    convert(8'd0,   12'h000);
    convert(8'd99,  12'h099);
    convert(8'd100, 12'h100);

    // Start requests during SHIFT must be ignored.
    @(negedge clk_311);
    start_311  = 1'b1;
    bin_in_311 = 8'd37;
    sb.push_back(12'h037);
    @(posedge clk_311);
    #1;
    bin_in_311 = 8'd200;
    wait_done(seen, bc);
    start_311 = 1'b0;
    checks++;
    if (bc != 8) begin
      errors++;
      $display("FAIL ignore_busy_cycles got %0d required 8", bc);
    end
    @(negedge clk_311);
    checks++;
    if (busy_311 !== 1'b0 || done_311 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_restart got busy=%b done=%b required 0 0", busy_311, done_311);
    end

    // Back-to-back with start held high.
    @(negedge clk_311);
    start_311  = 1'b1;
    bin_in_311 = 8'd128;
    sb.push_back(12'h128);
    sb.push_back(12'h064);
    @(posedge clk_311);
    #1;
    bin_in_311 = 8'd64;
    wait_done(seen, bc);
    t1 = cyc;
    @(posedge clk_311);
    #1;
    bin_in_311 = 8'd128;
    wait_done(seen, bc);
    t2 = cyc;
    start_311 = 1'b0;
    checks++;
    if (t2 - t1 != 9) begin
      errors++;
      $display("FAIL b2b_period got %0d required 9", t2 - t1);
    end
    @(negedge clk_311);
    checks++;
    if (busy_311 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got busy=%b required 0", busy_311);
    end

    // Reset mid-conversion aborts with no done.
    convert(8'd42, 12'h042);
    @(negedge clk_311);
    start_311  = 1'b1;
    bin_in_311 = 8'd250;
    @(posedge clk_311);
    #1;
    start_311 = 1'b0;
    repeat (4) @(posedge clk_311);
    #2;
    reset_311 = 1'b0;
    #1;
    checks++;
    if (busy_311 !== 1'b0 || done_311 !== 1'b0 || bcd_311 !== 12'h000) begin
      errors++;
      $display("FAIL abort_reset got busy=%b done=%b bcd=%h required 0 0 000",
               busy_311, done_311, bcd_311);
    end
    repeat (2) @(negedge clk_311);
    reset_311 = 1'b1;
    dcount = 0;
    repeat (12) begin
      @(negedge clk_311);
      dcount += int'(done_311);
    end
    checks++;
    if (dcount != 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d done pulses required 0", dcount);
    end
    convert(8'd250, 12'h250);

    // Sweep driven by a down counter.
    count_311 = 8'd255;
    for (int n = 0; n < 256; n++) begin
      convert(count_311, bcd_model(int'(count_311)));
      count_311 = count_311 - 8'd1;
    end

    repeat (2) @(negedge clk_311);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
